// File: rtl/key_event_decoder.sv
// Key event decoder: turns a strobed, debounced key level into press/release/click/double-click/long events.
// Latency: o_pressed and every event pulse update on the clock edge after the qualifying strobe or timer cycle.
// Backpressure: none; ivalid is a fire-and-forget qualifier and every pulse lasts exactly one cycle.
module key_event_decoder #(
  parameter int LONG_CNT     = 1_300_000,
  parameter int GAP_CNT      = 19_500_000,
  parameter bit ACTIVE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ikey,
  input  logic ivalid,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_dclick,
  output logic o_long
);

  // The timer only has to reach the larger threshold minus one; it is sized for that and saturates there.
  localparam int MAX_CNT = (LONG_CNT > GAP_CNT) ? LONG_CNT : GAP_CNT;
  localparam int TW      = $clog2(MAX_CNT);

  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CNT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CNT - 1);
  localparam logic [TW-1:0] TIMER_SAT = TW'(MAX_CNT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            level_q, level_d;
  logic            pressed_q, pressed_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            click_q, click_d;
  logic            dclick_q, dclick_d;
  logic            long_q, long_d;

  logic            press_edge;
  logic            release_edge;
  logic            timer_run;

  // A strobe only counts as an edge when it disagrees with the stored level; repeats are ignored.
  assign press_edge   = ivalid && (ikey == ACTIVE_LEVEL) && (level_q != ACTIVE_LEVEL);
  assign release_edge = ivalid && (ikey != ACTIVE_LEVEL) && (level_q == ACTIVE_LEVEL);

  // Next-state, level tracking, timer and event pulse generation.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    timer_run = (state_q == PRESS1) || (state_q == WAIT2) || (state_q == PRESS2);

    if (press_edge || release_edge) begin
      level_d = ikey;
    end

    if (timer_run && (timer_q != TIMER_SAT)) begin
      timer_d = timer_q + TW'(1);
    end

    // Edges are tested before timer expiry so that an edge in the expiry cycle wins.
    case (state_q)
      IDLE: begin
        if (press_edge) begin
          state_d = PRESS1;
          press_d = 1'b1;
        end
      end
      PRESS1: begin
        if (release_edge) begin
          state_d   = WAIT2;
          release_d = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_edge) begin
          state_d = PRESS2;
          press_d = 1'b1;
        end else if (timer_q == GAP_LAST) begin
          state_d = IDLE;
          click_d = 1'b1;
        end
      end
      PRESS2: begin
        if (release_edge) begin
          state_d   = IDLE;
          release_d = 1'b1;
          dclick_d  = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          // The first click already completed, so it is reported alongside the long hold.
          state_d = LONG_HOLD;
          click_d = 1'b1;
          long_d  = 1'b1;
        end
      end
      LONG_HOLD: begin
        // A long hold never turns into a click.
        if (release_edge) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state entry restarts the timer from zero.
    if (state_d != state_q) begin
      timer_d = '0;
    end

    pressed_d = (level_d == ACTIVE_LEVEL);
  end

  // State, timer, level and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      level_q   <= ~ACTIVE_LEVEL;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
    end
  end

  assign o_pressed = pressed_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_click   = click_q;
  assign o_dclick  = dclick_q;
  assign o_long    = long_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed click/double/long/tie/noise/reset scenarios plus randomized traffic.
// Latency: outputs recorded each cycle at the falling edge; a strobe in cycle k shows up in cycle k+1.
// Backpressure: none; stimulus is a per-cycle table replayed into the design.
module tb_key_event_decoder;

  localparam int LONG_CNT = 100;
  localparam int GAP_CNT  = 50;
  localparam bit ACT      = 1'b0;
  localparam bit REL      = 1'b1;
  localparam int MAXN     = 2048;
  localparam int BIG      = 1 << 30;

  // Bit positions in the recorded output vector.
  localparam int B_PRESSED = 5;
  localparam int B_PRESS   = 4;
  localparam int B_RELEASE = 3;
  localparam int B_CLICK   = 2;
  localparam int B_DCLICK  = 1;
  localparam int B_LONG    = 0;

  logic clk;
  logic rst_n;
  logic ikey;
  logic ivalid;
  logic o_pressed, o_press, o_release, o_click, o_dclick, o_long;

  logic [5:0] obs   [MAXN];
  logic [5:0] exp_v [MAXN];
  bit         stim_v[MAXN];
  bit         stim_k[MAXN];
  bit         stim_r[MAXN];

  int checks;
  int errors;

  key_event_decoder #(
    .LONG_CNT    (LONG_CNT),
    .GAP_CNT     (GAP_CNT),
    .ACTIVE_LEVEL(ACT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ikey     (ikey),
    .ivalid   (ivalid),
    .o_pressed(o_pressed),
    .o_press  (o_press),
    .o_release(o_release),
    .o_click  (o_click),
    .o_dclick (o_dclick),
    .o_long   (o_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_stim();
    for (int c = 0; c < MAXN; c++) begin
      stim_v[c] = 1'b0;
      stim_k[c] = REL;
      stim_r[c] = 1'b1;
      exp_v[c]  = '0;
      obs[c]    = '0;
    end
  endtask

  task automatic set_bit(input int t, input int b);
    if (t >= 0 && t < MAXN) exp_v[t][b] = 1'b1;
  endtask

  task automatic set_pressed(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) set_bit(c, B_PRESSED);
  endtask

  task automatic strobe(input int c, input bit k);
    stim_v[c] = 1'b1;
    stim_k[c] = k;
  endtask

  task automatic do_reset();
    ivalid = 1'b0;
    ikey   = REL;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Replays the stimulus table; obs[k] is what the design shows during cycle k.
  task automatic run_stim(input int n);
    do_reset();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs[k] = {o_pressed, o_press, o_release, o_click, o_dclick, o_long};
      rst_n  = stim_r[k];
      ivalid = stim_v[k];
      ikey   = stim_k[k];
    end
    ivalid = 1'b0;
    ikey   = REL;
  endtask

  // Event-level reference: works on the list of accepted edges and their cycle numbers.
  task automatic compute_expected(input int n);
    int et[$];
    bit lv;
    int i, p, r, p2;
    bit second;
    lv = REL;
    for (int c = 0; c < n; c++) begin
      exp_v[c][B_PRESSED] = (lv == ACT);
      if (stim_v[c] && stim_k[c] != lv) begin
        lv = stim_k[c];
        et.push_back(c);
      end
    end
    i = 0;
    second = 1'b0;
    while (i < et.size()) begin
      p = et[i];
      r = (i + 1 < et.size()) ? et[i+1] : BIG;
      set_bit(p + 1, B_PRESS);
      if (r - p <= LONG_CNT) begin
        set_bit(r + 1, B_RELEASE);
        if (second) begin
          set_bit(r + 1, B_DCLICK);
          second = 1'b0;
        end else begin
          p2 = (i + 2 < et.size()) ? et[i+2] : BIG;
          if (p2 - r <= GAP_CNT) second = 1'b1;
          else set_bit(r + GAP_CNT + 1, B_CLICK);
        end
      end else begin
        set_bit(p + LONG_CNT + 1, B_LONG);
        if (second) set_bit(p + LONG_CNT + 1, B_CLICK);
        second = 1'b0;
        if (r != BIG) set_bit(r + 1, B_RELEASE);
      end
      i += 2;
    end
    for (int c = n; c < MAXN; c++) exp_v[c] = '0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ivalid = 1'b1;
    ikey   = ACT;
    repeat (3) @(negedge clk);
    checks++; if (o_pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed got=%b expected=0", o_pressed); end
    checks++; if (o_press   !== 1'b0) begin errors++; $display("FAIL reset_press got=%b expected=0", o_press); end
    checks++; if (o_release !== 1'b0) begin errors++; $display("FAIL reset_release got=%b expected=0", o_release); end
    checks++; if (o_click   !== 1'b0) begin errors++; $display("FAIL reset_click got=%b expected=0", o_click); end
    checks++; if (o_dclick  !== 1'b0) begin errors++; $display("FAIL reset_dclick got=%b expected=0", o_dclick); end
    checks++; if (o_long    !== 1'b0) begin errors++; $display("FAIL reset_long got=%b expected=0", o_long); end
    ivalid = 1'b0;
    ikey   = REL;
  endtask

  task automatic test_single_click();
    clear_stim();
    strobe(10, ACT);
    strobe(30, REL);
    set_pressed(11, 30);
    set_bit(11, B_PRESS);
    set_bit(31, B_RELEASE);
    set_bit(81, B_CLICK);
    run_stim(160);
    for (int k = 0; k < 160; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL single_click cyc=%0d got=%b expected=%b", k, obs[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_double_click();
    clear_stim();
    strobe(10, ACT);
    strobe(30, REL);
    strobe(60, ACT);
    strobe(70, REL);
    set_pressed(11, 30);
    set_pressed(61, 70);
    set_bit(11, B_PRESS);
    set_bit(31, B_RELEASE);
    set_bit(61, B_PRESS);
    set_bit(71, B_RELEASE);
    set_bit(71, B_DCLICK);
    run_stim(200);
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL double_click cyc=%0d got=%b expected=%b", k, obs[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_long_press();
    clear_stim();
    strobe(10, ACT);
    strobe(300, REL);
    set_pressed(11, 300);
    set_bit(11, B_PRESS);
    set_bit(111, B_LONG);
    set_bit(301, B_RELEASE);
    run_stim(420);
    for (int k = 0; k < 420; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL long_press cyc=%0d got=%b expected=%b", k, obs[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_tie_cases();
    // Release lands in the cycle where the hold timer reads LONG_CNT-1.
    clear_stim();
    strobe(10, ACT);
    strobe(110, REL);
    set_pressed(11, 110);
    set_bit(11, B_PRESS);
    set_bit(111, B_RELEASE);
    set_bit(161, B_CLICK);
    run_stim(240);
    for (int k = 0; k < 240; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL tie_release_vs_long cyc=%0d got=%b expected=%b", k, obs[k], exp_v[k]);
      end
    end
    // Second press lands in the cycle where the gap timer reads GAP_CNT-1.
    clear_stim();
    strobe(10, ACT);
    strobe(30, REL);
    strobe(80, ACT);
    strobe(90, REL);
    set_pressed(11, 30);
    set_pressed(81, 90);
    set_bit(11, B_PRESS);
    set_bit(31, B_RELEASE);
    set_bit(81, B_PRESS);
    set_bit(91, B_RELEASE);
    set_bit(91, B_DCLICK);
    run_stim(220);
    for (int k = 0; k < 220; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL tie_press_vs_click cyc=%0d got=%b expected=%b", k, obs[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_noise();
    clear_stim();
    for (int c = 0; c < 150; c++) begin
      stim_k[c] = ($urandom_range(0, 1) == 1);
      if (c % 7 == 3) strobe(c, REL);
    end
    run_stim(150);
    for (int k = 0; k < 150; k++) begin
      checks++;
      if (obs[k] !== 6'b0) begin
        errors++;
        $display("FAIL noise cyc=%0d got=%b expected=000000", k, obs[k]);
      end
    end
  endtask

  task automatic test_reset_abort();
    clear_stim();
    strobe(10, ACT);
    strobe(30, REL);
    strobe(60, ACT);
    for (int c = 65; c < 70; c++) stim_r[c] = 1'b0;
    strobe(67, ACT);
    strobe(75, REL);
    strobe(80, ACT);
    strobe(90, REL);
    set_pressed(11, 30);
    set_pressed(61, 65);
    set_bit(11, B_PRESS);
    set_bit(31, B_RELEASE);
    set_bit(61, B_PRESS);
    set_pressed(81, 90);
    set_bit(81, B_PRESS);
    set_bit(91, B_RELEASE);
    set_bit(141, B_CLICK);
    run_stim(260);
    for (int k = 0; k < 260; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL reset_abort cyc=%0d got=%b expected=%b", k, obs[k], exp_v[k]);
      end
    end
  endtask

  // Random holds and gaps clustered around the thresholds, with noise and repeat strobes in between.
  task automatic test_random(input int round, input int n);
    bit lvl;
    int nxt, dur;
    clear_stim();
    lvl = REL;
    nxt = 5 + $urandom_range(0, 10);
    for (int c = 0; c < n; c++) begin
      if (c == nxt) begin
        lvl = ~lvl;
        strobe(c, lvl);
        if (lvl == ACT) begin
          case ($urandom_range(0, 3))
            0:       dur = $urandom_range(1, 20);
            1:       dur = $urandom_range(LONG_CNT - 3, LONG_CNT + 3);
            2:       dur = $urandom_range(1, 2 * LONG_CNT);
            default: dur = LONG_CNT + $urandom_range(0, 1);
          endcase
        end else begin
          case ($urandom_range(0, 3))
            0:       dur = $urandom_range(1, 20);
            1:       dur = $urandom_range(GAP_CNT - 3, GAP_CNT + 3);
            2:       dur = $urandom_range(1, 3 * GAP_CNT);
            default: dur = GAP_CNT + $urandom_range(0, 1);
          endcase
        end
        nxt = c + dur;
      end else begin
        stim_v[c] = ($urandom_range(0, 7) == 0);
        stim_k[c] = stim_v[c] ? lvl : ($urandom_range(0, 1) == 1);
      end
    end
    compute_expected(n);
    run_stim(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL random round=%0d cyc=%0d got=%b expected=%b", round, k, obs[k], exp_v[k]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ivalid = 1'b0;
    ikey   = REL;
    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_tie_cases();
    test_noise();
    test_reset_abort();
    for (int r = 0; r < 4; r++) test_random(r, 1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
